// File: rtl/fl_tools_pkg.sv
// Shared FrameLink helpers: frame-walk state encoding and REM port width.
package fl_tools_pkg;

    typedef enum logic [1:0] {
        FIRST  = 2'd0,
        SECOND = 2'd1,
        BODY   = 2'd2
    } fl_state_t;

    // Bits needed to address a byte lane inside one data word (never below 1).
    function automatic int unsigned rem_width(input int unsigned data_width);
        int unsigned w;
        w = $clog2(data_width / 8);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fl_first_extract.sv
// Strips the first word of every FrameLink frame onto a side port; the rest passes through.
// Define FL_FIRST_EXTRACT_CNT_EN to build the extracted-word counter behind FRAME_CNT.
module fl_first_extract
    import fl_tools_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned REM_WIDTH  = rem_width(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,

    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [REM_WIDTH-1:0]  RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,

    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [REM_WIDTH-1:0]  TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_EOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOP_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,

    output logic [DATA_WIDTH-1:0] EXT_DATA,
    output logic [REM_WIDTH-1:0]  EXT_REM,
    output logic                  EXT_VLD,
    input  logic                  EXT_RDY,

    output logic [31:0]           FRAME_CNT
);

    fl_state_t             state;
    fl_state_t             next_state;
    logic                  rx_rdy;
    logic                  rx_xfer;
    logic                  ext_load;
    logic [DATA_WIDTH-1:0] ext_data_q;
    logic [REM_WIDTH-1:0]  ext_rem_q;
    logic                  ext_vld_q;

    assign rx_xfer = rx_rdy && !RX_SRC_RDY_N;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= FIRST;
        end else begin
            state <= next_state;
        end
    end

    // Next state, RX backpressure and the zero-latency RX-to-TX path
    always_comb begin
        next_state   = state;
        rx_rdy       = 1'b0;
        ext_load     = 1'b0;
        TX_DATA      = RX_DATA;
        TX_REM       = RX_REM;
        TX_EOF_N     = RX_EOF_N;
        TX_EOP_N     = RX_EOP_N;
        TX_SOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;

        unique case (state)
            FIRST: begin
                // Only here may a full EXT register hold off RX.
                rx_rdy = !ext_vld_q || EXT_RDY;
                if (rx_xfer && !RX_SOF_N) begin
                    ext_load = 1'b1;
                    if (RX_EOF_N) begin
                        next_state = SECOND;
                    end
                end
            end
            SECOND: begin
                TX_SOF_N     = 1'b0;
                TX_SOP_N     = 1'b0;
                TX_SRC_RDY_N = RX_SRC_RDY_N;
                rx_rdy       = !TX_DST_RDY_N;
                if (rx_xfer) begin
                    next_state = RX_EOF_N ? BODY : FIRST;
                end
            end
            BODY: begin
                TX_SOP_N     = RX_SOP_N;
                TX_SRC_RDY_N = RX_SRC_RDY_N;
                rx_rdy       = !TX_DST_RDY_N;
                if (rx_xfer && !RX_EOF_N) begin
                    next_state = FIRST;
                end
            end
            default: begin
                next_state = FIRST;
            end
        endcase

        // Both handshakes stay closed while reset is held.
        if (!RESET_N) begin
            rx_rdy       = 1'b0;
            TX_SRC_RDY_N = 1'b1;
        end

        RX_DST_RDY_N = !rx_rdy;
    end

    // Extracted-word register; a load on the handshake edge keeps it valid
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ext_data_q <= '0;
            ext_rem_q  <= '0;
            ext_vld_q  <= 1'b0;
        end else if (ext_load) begin
            ext_data_q <= RX_DATA;
            ext_rem_q  <= RX_REM;
            ext_vld_q  <= 1'b1;
        end else if (ext_vld_q && EXT_RDY) begin
            ext_vld_q  <= 1'b0;
        end
    end

    assign EXT_DATA = ext_data_q;
    assign EXT_REM  = ext_rem_q;
    assign EXT_VLD  = ext_vld_q;

`ifdef FL_FIRST_EXTRACT_CNT_EN
    logic [31:0] frame_cnt_q;

    // Free-running count of extracted words, wraps naturally
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_cnt_q <= '0;
        end else if (ext_load) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign FRAME_CNT = frame_cnt_q;
`else
    assign FRAME_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_fl_first_extract.sv
// Self-checking bench for fl_first_extract: directed frames plus random traffic against a frame-level model.
module tb_fl_first_extract;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 2;
`ifdef FL_FIRST_EXTRACT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rem;
        logic          sof_n;
        logic          eof_n;
        logic          sop_n;
        logic          eop_n;
    } fl_word_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rem;
    } ext_word_t;

    logic          CLK;
    logic          RESET_N;
    logic [DW-1:0] RX_DATA;
    logic [RW-1:0] RX_REM;
    logic          RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N, RX_DST_RDY_N;
    logic [DW-1:0] TX_DATA;
    logic [RW-1:0] TX_REM;
    logic          TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N, TX_DST_RDY_N;
    logic [DW-1:0] EXT_DATA;
    logic [RW-1:0] EXT_REM;
    logic          EXT_VLD, EXT_RDY;
    logic [31:0]   FRAME_CNT;

    fl_first_extract #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .RX_DATA(RX_DATA), .RX_REM(RX_REM), .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N),
        .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N), .RX_SRC_RDY_N(RX_SRC_RDY_N),
        .RX_DST_RDY_N(RX_DST_RDY_N),
        .TX_DATA(TX_DATA), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
        .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N), .TX_SRC_RDY_N(TX_SRC_RDY_N),
        .TX_DST_RDY_N(TX_DST_RDY_N),
        .EXT_DATA(EXT_DATA), .EXT_REM(EXT_REM), .EXT_VLD(EXT_VLD), .EXT_RDY(EXT_RDY),
        .FRAME_CNT(FRAME_CNT)
    );

    int        total = 0;
    int        bad   = 0;
    int        exp_cnt = 0;
    bit        rand_tx = 1'b0;
    bit        f1_done = 1'b0;
    int        plen[$];
    fl_word_t  frame[$];
    fl_word_t  f1[$];
    fl_word_t  f2[$];
    fl_word_t  got_tx[$];
    fl_word_t  exp_tx[$];
    ext_word_t got_ext[$];
    ext_word_t exp_ext[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output backpressure: idle-ready, or a coin flip every cycle
    initial begin
        TX_DST_RDY_N = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            TX_DST_RDY_N = rand_tx ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Inputs settle at posedge+1, so a negedge sample shows what the next edge transfers
    always @(negedge CLK) begin
        if (RESET_N && !TX_SRC_RDY_N && !TX_DST_RDY_N)
            got_tx.push_back({TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N});
        if (RESET_N && EXT_VLD && EXT_RDY)
            got_ext.push_back({EXT_DATA, EXT_REM});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_parts(input int a, input int b, input int c);
        plen.delete();
        if (a > 0) plen.push_back(a);
        if (b > 0) plen.push_back(b);
        if (c > 0) plen.push_back(c);
    endtask

    // RX frame from the part lengths in plen: SOF on word 0, EOF on the last, SOP/EOP at part bounds
    task automatic build_frame(input logic [DW-1:0] base, input bit rnd);
        fl_word_t w;
        int nwords = 0;
        int idx = 0;
        frame.delete();
        foreach (plen[p]) nwords += plen[p];
        foreach (plen[p]) begin
            for (int k = 0; k < plen[p]; k++) begin
                w.data  = rnd ? DW'($urandom) : base + DW'(idx);
                w.rem   = RW'($urandom_range(0, 3));
                w.sof_n = (idx != 0);
                w.eof_n = (idx != nwords - 1);
                w.sop_n = (k != 0);
                w.eop_n = (k != plen[p] - 1);
                frame.push_back(w);
                idx++;
            end
        end
    endtask

    // Expected outcome: word 0 goes to EXT, the rest to TX with the new start flagged SOF+SOP
    task automatic model_frame(input fl_word_t ws[$], input int upto);
        fl_word_t w;
        exp_ext.push_back({ws[0].data, ws[0].rem});
        exp_cnt++;
        for (int i = 1; i < upto; i++) begin
            w = ws[i];
            w.sof_n = (i != 1);
            if (i == 1) w.sop_n = 1'b0;
            exp_tx.push_back(w);
        end
    endtask

    task automatic send_word(input fl_word_t w, input int gap);
        bit acc = 1'b0;
        RX_SRC_RDY_N = 1'b1;
        tick(gap);
        {RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N} = w;
        RX_SRC_RDY_N = 1'b0;
        for (int c = 0; c < 400 && !acc; c++) begin
            @(negedge CLK);
            acc = !RX_DST_RDY_N;
            @(posedge CLK);
            #1;
        end
        RX_SRC_RDY_N = 1'b1;
        total++;
        assert (acc === 1'b1) else begin
            bad++;
            $error("FAIL rx_accept_timeout observed=%0b expected=1 data=%h", acc, w.data);
        end
    endtask

    task automatic send_words(input fl_word_t ws[$], input int upto, input int gap_max);
        for (int i = 0; i < upto; i++) send_word(ws[i], $urandom_range(0, gap_max));
    endtask

    task automatic check_streams(input string tag);
        check({tag, "_tx_count"}, 64'(got_tx.size()), 64'(exp_tx.size()));
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++) begin
            total++;
            assert (got_tx[i] === exp_tx[i]) else begin
                bad++;
                $error("FAIL %s_tx[%0d] observed=%h expected=%h", tag, i, got_tx[i], exp_tx[i]);
            end
        end
        check({tag, "_ext_count"}, 64'(got_ext.size()), 64'(exp_ext.size()));
        for (int i = 0; i < got_ext.size() && i < exp_ext.size(); i++) begin
            total++;
            assert (got_ext[i] === exp_ext[i]) else begin
                bad++;
                $error("FAIL %s_ext[%0d] observed=%h expected=%h", tag, i, got_ext[i], exp_ext[i]);
            end
        end
        got_tx.delete();
        exp_tx.delete();
        got_ext.delete();
        exp_ext.delete();
    endtask

    task automatic check_cnt(input string tag);
        check(tag, 64'(FRAME_CNT), CNT_EN ? 64'(exp_cnt) : 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_dst_rdy_n"}, 64'(RX_DST_RDY_N), 64'd1);
        check({tag, "_tx_src_rdy_n"}, 64'(TX_SRC_RDY_N), 64'd1);
        check({tag, "_ext_vld"},      64'(EXT_VLD),      64'd0);
        check({tag, "_ext_data"},     64'(EXT_DATA),     64'd0);
        check({tag, "_ext_rem"},      64'(EXT_REM),      64'd0);
        check({tag, "_frame_cnt"},    64'(FRAME_CNT),    64'd0);
    endtask

    initial begin
        int n_sop;
        RESET_N      = 1'b0;
        RX_DATA      = '0;
        RX_REM       = '0;
        RX_SOF_N     = 1'b1;
        RX_EOF_N     = 1'b1;
        RX_SOP_N     = 1'b1;
        RX_EOP_N     = 1'b1;
        RX_SRC_RDY_N = 1'b1;
        EXT_RDY      = 1'b1;

        // Reset state
        tick(3);
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        tick(2);

        // Four-word frame
        set_parts(4, 0, 0);
        build_frame(32'hA0, 1'b0);
        model_frame(frame, frame.size());
        send_words(frame, frame.size(), 0);
        tick(3);
        check("s1_ext_data", 64'(EXT_DATA), 64'h0000_00A0);
        check_cnt("s1_frame_cnt");
        check_streams("s1");

        // Single-word frame: EXT only, and the walk is back at frame start
        set_parts(1, 0, 0);
        build_frame(32'hB0, 1'b0);
        model_frame(frame, frame.size());
        send_words(frame, frame.size(), 0);
        tick(3);
        check("s2_ext_data", 64'(EXT_DATA), 64'h0000_00B0);
        RX_SOF_N = 1'b0;
        RX_SRC_RDY_N = 1'b0;
        #2;
        check("s2_idle_tx_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
        check("s2_idle_rx_dst_rdy_n", 64'(RX_DST_RDY_N), 64'd0);
        RX_SRC_RDY_N = 1'b1;
        tick(1);
        check_cnt("s2_frame_cnt");
        check_streams("s2");

        // Back-to-back frames while the EXT consumer is stalled
        EXT_RDY = 1'b0;
        set_parts(2, 0, 0);
        build_frame(32'hD0, 1'b0);
        f1 = frame;
        build_frame(32'hE0, 1'b0);
        f2 = frame;
        model_frame(f1, f1.size());
        model_frame(f2, f2.size());
        f1_done = 1'b0;
        fork
            begin
                send_words(f1, f1.size(), 0);
                f1_done = 1'b1;
                send_words(f2, f2.size(), 0);
            end
            begin
                wait (f1_done);
                tick(4);
                check("s3_stall_rx_dst_rdy_n", 64'(RX_DST_RDY_N), 64'd1);
                check("s3_stall_ext_data", 64'(EXT_DATA), 64'h0000_00D0);
                EXT_RDY = 1'b1;
                tick(1);
                EXT_RDY = 1'b0;
                check("s3_reload_ext_vld", 64'(EXT_VLD), 64'd1);
            end
        join
        tick(2);
        check("s3_ext_data", 64'(EXT_DATA), 64'h0000_00E0);
        check("s3_ext_vld_held", 64'(EXT_VLD), 64'd1);
        EXT_RDY = 1'b1;
        tick(3);
        check_cnt("s3_frame_cnt");
        check_streams("s3");

        // Header part of one word: three parts in, two parts out
        set_parts(1, 2, 2);
        build_frame(32'hF0, 1'b0);
        model_frame(frame, frame.size());
        send_words(frame, frame.size(), 0);
        tick(3);
        n_sop = 0;
        foreach (got_tx[i]) if (!got_tx[i].sop_n) n_sop++;
        check("s4_tx_parts", 64'(n_sop), 64'd2);
        check_streams("s4");

        // Random frames with random output backpressure and input gaps
        rand_tx = 1'b1;
        for (int f = 0; f < 10; f++) begin
            set_parts($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3));
            build_frame('0, 1'b1);
            model_frame(frame, frame.size());
            send_words(frame, frame.size(), 2);
        end
        rand_tx = 1'b0;
        tick(4);
        check_cnt("s5_frame_cnt");
        check_streams("s5");

        // Reset in the middle of a frame, then a fresh two-word frame
        set_parts(4, 0, 0);
        build_frame(32'h90, 1'b0);
        model_frame(frame, 2);
        send_words(frame, 2, 0);
        tick(3);
        check_streams("s6_pre");
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("s6_reset");
        exp_cnt = 0;
        tick(2);
        RESET_N = 1'b1;
        tick(2);
        set_parts(2, 0, 0);
        build_frame(32'hC0, 1'b0);
        model_frame(frame, frame.size());
        send_words(frame, frame.size(), 0);
        tick(3);
        check("s6_ext_data", 64'(EXT_DATA), 64'h0000_00C0);
        check_cnt("s6_frame_cnt");
        total++;
        assert (got_tx.size() == 1 && got_tx[0].data === 32'hC1 && got_tx[0].sof_n === 1'b0
                && got_tx[0].sop_n === 1'b0 && got_tx[0].eof_n === 1'b0) else begin
            bad++;
            $error("FAIL s6_tx_word observed_count=%0d expected=1 word C1 with SOF/SOP/EOF", got_tx.size());
        end
        check_streams("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
